// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus.
// Groups the decode-side read/issue signals, the write-back port and the
// clear handshake between the pipeline (master) and the register file (slave).
//   init_req            master -> slave  soft clear request
//   ready               slave  -> master file usable (RUN)
//   rs1_addr/rs2_addr   master -> slave  read addresses
//   rs1_data/rs2_data   slave  -> master read data (combinational)
//   rs1_busy/rs2_busy   slave  -> master pending producer on the read register
//   issue_valid/rd      master -> slave  mark destination pending
//   wb_valid/rd/data    master -> slave  write-back port
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            init_req;
  logic            ready;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output init_req, rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
    input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy
  );

  modport slave (
    input  init_req, rs1_addr, rs2_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
    output ready, rs1_data, rs2_data, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with pending scoreboard.
// NREGS x XLEN storage, two combinational read ports, one write-back port,
// optional write-to-read bypass and a per-register pending bit for hazard
// detection. The array has no flop reset; a clear FSM walks registers
// 1..NREGS-1 after reset or init_req so the storage can map to RAM.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_scoreboard_if.slave (reads, issue, write-back, init/ready)
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);
  localparam int          AW      = $clog2(NREGS);
  localparam bit          BYP     = (BYPASS != 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e           state_r;
  logic             ready_r;
  logic [AW-1:0]    clr_ptr_r;
  logic [NREGS-1:0] pending_r;
  logic [XLEN-1:0]  mem_r [NREGS];

  logic             run_s;
  logic             wr_en_s;
  logic [NREGS-1:0] wb_mask_s;
  logic [NREGS-1:0] issue_mask_s;
  logic [NREGS-1:0] pending_nxt_s;
  logic             byp1_s;
  logic             byp2_s;

  assign run_s = (state_r == ST_RUN);

  // Write-back enable and scoreboard next-state; issue is OR-ed after the
  // write-back clear so a same-cycle newer producer keeps the bit set.
  always_comb begin
    wr_en_s      = run_s && bus.wb_valid && (bus.wb_rd != '0) && !bus.init_req;
    wb_mask_s    = '0;
    issue_mask_s = '0;
    wb_mask_s[bus.wb_rd]       = bus.wb_valid;
    issue_mask_s[bus.issue_rd] = bus.issue_valid;
    // Bit 0 is forced low: x0 is never pending.
    pending_nxt_s = ((pending_r & ~wb_mask_s) | issue_mask_s) & ~{{(NREGS-1){1'b0}}, 1'b1};
  end

  // Clear/run FSM with scoreboard bits and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_CLEAR;
      ready_r   <= 1'b0;
      clr_ptr_r <= AW'(1);
      pending_r <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          pending_r <= '0;
          clr_ptr_r <= clr_ptr_r + AW'(1);
          if (clr_ptr_r == LAST_IDX) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end else begin
            state_r <= ST_CLEAR;
            ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.init_req) begin
            state_r   <= ST_CLEAR;
            ready_r   <= 1'b0;
            clr_ptr_r <= AW'(1);
            pending_r <= '0;
          end else begin
            pending_r <= pending_nxt_s;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          ready_r   <= 1'b0;
          clr_ptr_r <= AW'(1);
          pending_r <= '0;
        end
      endcase
    end
  end

  // Storage: cleared one entry per cycle by the FSM, otherwise written by write-back.
  always_ff @(posedge clk) begin
    if (!run_s) begin
      mem_r[clr_ptr_r] <= '0;
    end else if (wr_en_s) begin
      mem_r[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Read ports: x0 and the clearing state read zero; bypass forwards a live write-back.
  always_comb begin
    byp1_s = BYP && bus.wb_valid && (bus.wb_rd == bus.rs1_addr);
    byp2_s = BYP && bus.wb_valid && (bus.wb_rd == bus.rs2_addr);
    if (!run_s || (bus.rs1_addr == '0)) begin
      bus.rs1_data = '0;
      bus.rs1_busy = 1'b0;
    end else begin
      bus.rs1_data = byp1_s ? bus.wb_data : mem_r[bus.rs1_addr];
      bus.rs1_busy = pending_r[bus.rs1_addr] && !byp1_s;
    end
    if (!run_s || (bus.rs2_addr == '0)) begin
      bus.rs2_data = '0;
      bus.rs2_busy = 1'b0;
    end else begin
      bus.rs2_data = byp2_s ? bus.wb_data : mem_r[bus.rs2_addr];
      bus.rs2_busy = pending_r[bus.rs2_addr] && !byp2_s;
    end
  end

  assign bus.ready = ready_r;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a BYPASS=1 and a BYPASS=0 instance share
// clock, reset and stimulus. Inputs change on the falling edge, outputs are
// sampled 1 ns later, well before the next rising edge.
module tb_regfile_scoreboard;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) bus  ();
  regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) bus0 ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  regfile_scoreboard #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        isv;
    logic [4:0]  isrd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;    // bypass DUT rs1_data
    logic [31:0] e2;    // bypass DUT rs2_data
    logic        eb1;   // bypass DUT rs1_busy
    logic        eb2;   // bypass DUT rs2_busy
    logic [31:0] e0;    // no-bypass DUT rs1_data
    logic        eb0;   // no-bypass DUT rs1_busy
  } vec_t;

  vec_t vt [15];
  vec_t eq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input logic isv, input logic [4:0] isrd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic init);
    bus.wb_valid  = wbv;  bus0.wb_valid  = wbv;
    bus.wb_rd     = wbrd; bus0.wb_rd     = wbrd;
    bus.wb_data   = wbd;  bus0.wb_data   = wbd;
    bus.issue_valid = isv;  bus0.issue_valid = isv;
    bus.issue_rd    = isrd; bus0.issue_rd    = isrd;
    bus.rs1_addr  = a1;   bus0.rs1_addr  = a1;
    bus.rs2_addr  = a2;   bus0.rs2_addr  = a2;
    bus.init_req  = init; bus0.init_req  = init;
  endtask

  // Counts falling edges until ready; optionally injects a write-back to x5
  // at clear cycle inject_at and checks it is not visible.
  task automatic wait_ready(input string nm, input int inject_at, input int exp_n);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      if (n == inject_at) begin
        drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        #1;
        chk({nm, "_clr_rd"}, bus.rs1_data, 32'h0);
        chk({nm, "_clr_busy"}, {31'd0, bus.rs1_busy}, 32'd0);
      end
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
      n++;
    end
    chk({nm, "_latency"}, n, exp_n);
    chk({nm, "_ready0"}, {31'd0, bus0.ready}, 32'd1);
  endtask

  initial begin
    vec_t e;
    total = 0;
    bad   = 0;
    //          wbv   wbrd   wbd            isv   isrd   a1     a2     e1             e2             eb1   eb2   e0             eb0
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd7, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        1'b0};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd7, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        1'b1};
    vt[6]  = '{1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 5'd3, 5'd3, 32'h00000033, 32'h00000033, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h00000033, 32'h0,        1'b0, 1'b0, 32'h00000033, 1'b0};
    vt[8]  = '{1'b1, 5'd3, 32'h00000044, 1'b1, 5'd3, 5'd3, 5'd3, 32'h00000044, 32'h00000044, 1'b0, 1'b0, 32'h00000033, 1'b0};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h00000044, 32'h00000044, 1'b1, 1'b1, 32'h00000044, 1'b1};
    vt[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0, 32'h00000044, 32'h0,        1'b1, 1'b0, 32'h00000044, 1'b1};
    vt[11] = '{1'b1, 5'd3, 32'h00000055, 1'b1, 5'd0, 5'd3, 5'd0, 32'h00000055, 32'h0,        1'b0, 1'b0, 32'h00000044, 1'b1};
    vt[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h00000055, 32'h0,        1'b0, 1'b0, 32'h00000055, 1'b0};
    vt[13] = '{1'b1, 5'd9, 32'h00000055, 1'b1, 5'd9, 5'd9, 5'd3, 32'h00000055, 32'h00000055, 1'b0, 1'b0, 32'h0,        1'b0};
    vt[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h00000055, 32'h00000055, 1'b1, 1'b1, 32'h00000055, 1'b1};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_rs1", bus.rs1_data, 32'h0);
    chk("rst_busy", {31'd0, bus.rs1_busy}, 32'd0);

    // Reset release: 31 clear cycles, write-back during clear discarded
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("rel", 20, 31);
    #1;
    chk("clr_wb_dropped", bus.rs1_data, 32'h0);
    chk("clr_issue_dropped", {31'd0, bus.rs1_busy}, 32'd0);

    // Table-driven RUN vectors through the expectation queue
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vt[i].wbv, vt[i].wbrd, vt[i].wbd, vt[i].isv, vt[i].isrd, vt[i].a1, vt[i].a2, 1'b0);
      eq.push_back(vt[i]);
      #1;
      e = eq.pop_front();
      chk($sformatf("v%0d_rs1", i), bus.rs1_data, e.e1);
      chk($sformatf("v%0d_rs2", i), bus.rs2_data, e.e2);
      chk($sformatf("v%0d_busy1", i), {31'd0, bus.rs1_busy}, {31'd0, e.eb1});
      chk($sformatf("v%0d_busy2", i), {31'd0, bus.rs2_busy}, {31'd0, e.eb2});
      chk($sformatf("v%0d_nb_rs1", i), bus0.rs1_data, e.e0);
      chk($sformatf("v%0d_nb_busy1", i), {31'd0, bus0.rs1_busy}, {31'd0, e.eb0});
    end

    // init_req in RUN: x9 holds 0x55 and is pending
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5, 1'b1);
    #1;
    chk("init_ready_same", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5, 1'b0);
    #1;
    chk("init_ready", {31'd0, bus.ready}, 32'd0);
    chk("init_rd", bus.rs1_data, 32'h0);
    wait_ready("init", -1, 31);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5, 1'b0);
    #1;
    chk("init_x9", bus.rs1_data, 32'h0);
    chk("init_x9_busy", {31'd0, bus.rs1_busy}, 32'd0);
    chk("init_x5", bus.rs2_data, 32'h0);

    // Async reset pulse mid-clear (clr_ptr=10), no clock edge during the pulse
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_ready", {31'd0, bus.ready}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk("pulse_ready", {31'd0, bus.ready}, 32'd0);
    wait_ready("pulse", -1, 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
